// File: rtl/lfsr_search_pkg.sv
// lfsr_search_pkg: shared state encoding, default widths and LFSR helper functions
package lfsr_search_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, WRITE, LOAD, ISSUE, WAIT, DONE} state_t;
  // number of distinct nonzero states of a (d+1)-bit maximal LFSR
  function automatic logic [31:0] lfsr_period(input logic [3:0] d);
    return (32'd1 << ({1'b0, d} + 5'd1)) - 32'd1;
  endfunction
  function automatic logic [3:0] msb_idx(input logic [31:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction
endpackage

// File: rtl/lfsr_search_arb.sv
// lfsr_search_arb: two-requester round-robin grant with a last-served flag
// ports: clk, rst_n (async active-low), en (grant window), wr_req/rd_req in, gnt_wr/gnt_rd out
module lfsr_search_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic wr_req,
  input  logic rd_req,
  output logic gnt_wr,
  output logic gnt_rd
);
  logic last_wr;
  assign gnt_wr = en && wr_req && (!rd_req || !last_wr);
  assign gnt_rd = en && rd_req && (!wr_req || last_wr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_wr <= 1'b0;
    else if (gnt_wr || gnt_rd) last_wr <= gnt_wr;
endmodule

// File: rtl/lfsr_search_ctrl.sv
// lfsr_search_ctrl: write/search sequencer for the LFSR-addressed associative memory
// ports: clk, rst_n (async active-low); host wr_req/wr_data/wr_ack, rd_req/rd_key/rd_ack;
//   memory mem_addr/mem_wdata/mem_we/mem_re/mem_rdata; LFSR lfsr_reset/lfsr_step/lfsr_degree/lfsr_out;
//   status done/found/found_addr/busy/full/entry_count; probe_count when LFSR_SEARCH_STATS_EN is defined
module lfsr_search_ctrl
  import lfsr_search_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [DATA_W-1:0] rd_key,
  output logic              rd_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lfsr_reset,
  output logic              lfsr_step,
  output logic [3:0]        lfsr_degree,
  input  logic [ADDR_W-1:0] lfsr_out,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] found_addr,
  output logic              busy,
  output logic              full,
`ifdef LFSR_SEARCH_STATS_EN
  output logic [ADDR_W-1:0] entry_count,
  output logic [ADDR_W-1:0] probe_count
`else
  output logic [ADDR_W-1:0] entry_count
`endif
);
  state_t state;
  logic [DATA_W-1:0] key;
  logic [ADDR_W-1:0] probe, cap_addr, wr_addr;
  logic [31:0] per;
  logic gnt_wr, gnt_rd, hit, last;
  assign per = lfsr_period(lfsr_degree);
  assign hit = mem_rdata == key;
  assign last = 32'(probe) == per;
  assign busy = state != IDLE;
  assign full = entry_count == '1;
  // step decision depends on read data returned during WAIT, so it cannot be registered
  assign lfsr_step = state == WAIT && !hit && !last;
  // during ISSUE the LFSR has already moved to the probe address
  assign mem_addr = mem_re ? lfsr_out : wr_addr;
  lfsr_search_arb u_arb (
    .clk(clk), .rst_n(rst_n), .en(state == IDLE),
    .wr_req(wr_req), .rd_req(rd_req), .gnt_wr(gnt_wr), .gnt_rd(gnt_rd)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      mem_wdata <= '0;
      wr_addr <= '0;
      lfsr_reset <= 1'b0;
      lfsr_degree <= '0;
      done <= 1'b0;
      found <= 1'b0;
      found_addr <= '0;
      entry_count <= '0;
      key <= '0;
      probe <= '0;
      cap_addr <= '0;
    end else begin
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      lfsr_reset <= 1'b0;
      done <= 1'b0;
      lfsr_degree <= msb_idx(32'(entry_count));
      case (state)
        IDLE:
          if (gnt_wr) begin
            state <= WRITE;
            wr_ack <= 1'b1;
            mem_we <= !full;
            wr_addr <= entry_count + 1'b1;
            mem_wdata <= wr_data;
            if (!full) entry_count <= entry_count + 1'b1;
          end else if (gnt_rd) begin
            state <= LOAD;
            rd_ack <= 1'b1;
            key <= rd_key;
            probe <= '0;
            found <= 1'b0;
            found_addr <= '0;
            lfsr_reset <= entry_count != '0;
          end
        WRITE: state <= IDLE;
        LOAD:
          if (entry_count == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            state <= ISSUE;
            mem_re <= 1'b1;
          end
        ISSUE: begin
          state <= WAIT;
          cap_addr <= lfsr_out;
          probe <= probe + 1'b1;
        end
        WAIT:
          if (hit) begin
            state <= DONE;
            done <= 1'b1;
            found <= 1'b1;
            found_addr <= cap_addr;
          end else if (last) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            state <= ISSUE;
            mem_re <= 1'b1;
          end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef LFSR_SEARCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) probe_count <= '0;
    else if (state == DONE) probe_count <= probe;
`endif
endmodule

// File: tb/tb_lfsr_search_ctrl.sv
// tb_lfsr_search_ctrl: directed vector bench with memory and reference LFSR models
module tb_lfsr_search_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_req = 1'b0, rd_req = 1'b0;
  logic [7:0] wr_data = '0, rd_key = '0, mem_wdata, mem_rdata = '0;
  logic wr_ack, rd_ack, mem_we, mem_re, lfsr_reset, lfsr_step, done, found, busy, full;
  logic [15:0] mem_addr, lfsr_out, found_addr, entry_count;
  logic [3:0] lfsr_degree;
`ifdef LFSR_SEARCH_STATS_EN
  logic [15:0] probe_count;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  lfsr_search_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_key(rd_key), .rd_ack(rd_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .lfsr_reset(lfsr_reset), .lfsr_step(lfsr_step), .lfsr_degree(lfsr_degree),
    .lfsr_out(lfsr_out), .done(done), .found(found), .found_addr(found_addr),
    .busy(busy), .full(full),
`ifdef LFSR_SEARCH_STATS_EN
    .entry_count(entry_count), .probe_count(probe_count)
`else
    .entry_count(entry_count)
`endif
  );

  logic [7:0] mem [0:15] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[3:0]];
  end

  // reference Fibonacci LFSR, taps x^n + x^(n-1) + 1 (maximal for n = 2..4), seed 1
  function automatic logic [3:0] lfsr_nxt(input logic [3:0] v, input logic [3:0] d);
    int k;
    logic fb;
    logic [4:0] mask;
    k = int'(d) + 1;
    if (k < 2) return v;
    fb = v[k-1] ^ v[k-2];
    mask = (5'd1 << k) - 5'd1;
    return 4'((({1'b0, v} << 1) | {4'd0, fb}) & mask);
  endfunction
  logic [3:0] lf;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) lf <= 4'd1;
    else if (lfsr_reset) lf <= 4'd1;
    else if (lfsr_step) lf <= lfsr_nxt(lf, lfsr_degree);
  assign lfsr_out = {12'd0, lf};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] d, output int ack_c, output int we_n,
                          output logic [15:0] we_a, output logic [7:0] we_d);
    ack_c = -1; we_n = 0; we_a = '0; we_d = '0;
    @(negedge clk);
    wr_req = 1'b1; wr_data = d;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_we) begin we_n++; we_a = mem_addr; we_d = mem_wdata; end
      if (wr_ack && ack_c < 0) begin ack_c = c; wr_req = 1'b0; end
      if (ack_c > 0 && !busy) break;
    end
    wr_req = 1'b0;
  endtask

  task automatic do_search(input logic [7:0] k, output int ack_c, output int done_c,
                           output int re_n, output int st_n, output int lr_n,
                           output logic fnd, output logic [15:0] fa);
    ack_c = -1; done_c = -1; re_n = 0; st_n = 0; lr_n = 0; fnd = 1'bx; fa = 'x;
    @(negedge clk);
    rd_req = 1'b1; rd_key = k;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (mem_re) re_n++;
      if (lfsr_step) st_n++;
      if (lfsr_reset) lr_n++;
      if (rd_ack && ack_c < 0) begin ack_c = c; rd_req = 1'b0; end
      if (done) begin done_c = c; fnd = found; fa = found_addr; break; end
    end
    rd_req = 1'b0;
    @(negedge clk);
`ifdef LFSR_SEARCH_STATS_EN
    chk("probe_count", 32'(probe_count), 32'(re_n));
`endif
  endtask

  // both requests raised together; cycle numbers count from the grant cycle
  task automatic do_both(input logic [7:0] d, output int wr_c, output int rd_c,
                         output int done_c, output logic fnd, output logic [15:0] fa);
    wr_c = -1; rd_c = -1; done_c = -1; fnd = 1'bx; fa = 'x;
    @(negedge clk);
    wr_req = 1'b1; wr_data = d; rd_req = 1'b1; rd_key = d;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (wr_ack && wr_c < 0) begin wr_c = c; wr_req = 1'b0; end
      if (rd_ack && rd_c < 0) begin rd_c = c; rd_req = 1'b0; end
      if (done) begin done_c = c; fnd = found; fa = found_addr; end
      if (wr_c > 0 && done_c > 0 && !busy) break;
    end
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  typedef struct {
    bit          is_rd;
    logic [7:0]  data;
    bit          exp_found;
    logic [15:0] exp_addr;
    int          exp_n;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t vt [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ac, dc, rn, sn, ln, wn, wc, rc;
    logic f, got;
    logic [15:0] a;
    logic [7:0] wd;
    // LFSR order at degree 1 is 1,3,2
    vt[0] = '{1'b1, 8'h55, 1'b0, 16'd0, 0, 16'd0};
    vt[1] = '{1'b0, 8'hA1, 1'b0, 16'd1, 1, 16'd1};
    vt[2] = '{1'b0, 8'hB2, 1'b0, 16'd2, 1, 16'd2};
    vt[3] = '{1'b0, 8'hC3, 1'b0, 16'd3, 1, 16'd3};
    vt[4] = '{1'b1, 8'hC3, 1'b1, 16'd3, 2, 16'd3};
    vt[5] = '{1'b1, 8'hEE, 1'b0, 16'd0, 3, 16'd3};
    vt[6] = '{1'b1, 8'hA1, 1'b1, 16'd1, 1, 16'd3};
    vt[7] = '{1'b1, 8'hB2, 1'b1, 16'd2, 3, 16'd3};

    repeat (2) @(negedge clk);
    chk("rst_strobes", 32'({wr_ack, rd_ack, mem_we, mem_re, lfsr_reset, lfsr_step, done, found, busy, full}), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_found_addr", 32'(found_addr), 0);
    chk("rst_degree", 32'(lfsr_degree), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_count", 32'(entry_count), 0);
    chk("rel_busy", 32'(busy), 0);

    for (int i = 0; i < 8; i++) begin
      if (vt[i].is_rd) begin
        do_search(vt[i].data, ac, dc, rn, sn, ln, f, a);
        chk($sformatf("v%0d_rd_ack_lat", i), 32'(ac), 1);
        chk($sformatf("v%0d_re_n", i), 32'(rn), 32'(vt[i].exp_n));
        chk($sformatf("v%0d_step_n", i), 32'(sn), 32'(vt[i].exp_n > 0 ? vt[i].exp_n - 1 : 0));
        chk($sformatf("v%0d_lreset_n", i), 32'(ln), 32'(vt[i].exp_cnt != 0 ? 1 : 0));
        chk($sformatf("v%0d_done_lat", i), 32'(dc), 32'(2 + 2 * vt[i].exp_n));
        chk($sformatf("v%0d_found", i), 32'(f), 32'(vt[i].exp_found));
        chk($sformatf("v%0d_found_addr", i), 32'(a), 32'(vt[i].exp_addr));
      end else begin
        do_write(vt[i].data, ac, wn, a, wd);
        chk($sformatf("v%0d_wr_ack_lat", i), 32'(ac), 1);
        chk($sformatf("v%0d_we_n", i), 32'(wn), 1);
        chk($sformatf("v%0d_we_addr", i), 32'(a), 32'(vt[i].exp_addr));
        chk($sformatf("v%0d_we_data", i), 32'(wd), 32'(vt[i].data));
      end
      chk($sformatf("v%0d_count", i), 32'(entry_count), 32'(vt[i].exp_cnt));
    end
    chk("degree_3", 32'(lfsr_degree), 1);
    chk("full_3", 32'(full), 0);

    // arbitration from reset: write first, then search
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_both(8'h11, wc, rc, dc, f, a);
    chk("arb0_wr_c", 32'(wc), 1);
    chk("arb0_rd_c", 32'(rc), 3);
    chk("arb0_found", 32'(f), 1);
    chk("arb0_found_addr", 32'(a), 1);
    // last served was the search, so write wins again
    do_both(8'h22, wc, rc, dc, f, a);
    chk("arb1_wr_c", 32'(wc), 1);
    chk("arb1_rd_c", 32'(rc), 3);
    chk("arb1_found_addr", 32'(a), 2);
    // after a lone write the search wins
    do_write(8'h33, ac, wn, a, wd);
    chk("solo_we_addr", 32'(a), 3);
    do_both(8'h33, wc, rc, dc, f, a);
    chk("arb2_rd_c", 32'(rc), 1);
    chk("arb2_done_c", 32'(dc), 6);
    chk("arb2_wr_c", 32'(wc), 32'(dc + 2));
    chk("arb2_found_addr", 32'(a), 3);
    chk("arb2_count", 32'(entry_count), 4);

    // reset asserted while a probe is in WAIT
    got = 1'b0;
    @(negedge clk);
    rd_req = 1'b1; rd_key = 8'hEE;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (rd_ack) rd_req = 1'b0;
      if (mem_re) got = 1'b1;
    end
    rd_req = 1'b0;
    chk("mid_issue_seen", 32'(got), 1);
    @(negedge clk);
    chk("mid_wait_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_re", 32'(mem_re), 0);
    chk("mid_rst_count", 32'(entry_count), 0);
    chk("mid_rst_step", 32'(lfsr_step), 0);
    @(negedge clk); rst_n = 1'b1;
    do_search(8'h11, ac, dc, rn, sn, ln, f, a);
    chk("post_rst_re_n", 32'(rn), 0);
    chk("post_rst_done_lat", 32'(dc), 2);
    chk("post_rst_found", 32'(f), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
